cnu_msg_expand: RTL and testbench
=================================

Name: cnu_msg_expand

Overview:
- Back end of the min-sum check-node unit. It accepts one compressed check-node result per frame: min, min2, min_idx and the D input signs.
- It expands that result into D check-to-variable messages and emits them serially, one edge per cycle, in sign-magnitude form.
- Applies offset min-sum correction.
- Sits between the min/min2 comparator tree and the variable-node message memory. Uses valid/ready on both sides.

Parameters:
- data_w, 9, magnitude width of min/min2 and of output magnitude
- idx_w, 3, width of min_idx and edge counter; 2^idx_w >= D
- D, 7, check-node degree (edges per frame), 2..2^idx_w
- OFFSET, 1, offset subtracted from each magnitude, saturating at 0

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-low (reset when 0)
- in_valid  in  1  compressed frame present
- in_ready  out  1  block can accept a frame this cycle
- min  in  data_w  smallest input magnitude
- min2  in  data_w  second-smallest magnitude
- min_idx  in  idx_w  edge index of min
- sign_in  in  D  sign bit of each input message, bit k = edge k
- out_valid  out  1  message present
- out_ready  in  1  downstream accepts message
- out_msg  out  data_w+1  {sign, magnitude}
- out_idx  out  idx_w  edge index of out_msg
- out_last  out  1  out_idx == D-1

Behaviour:
- Reset (rst==0 at a clk edge): state IDLE; out_valid=0, out_msg=0, out_idx=0, out_last=0; holding registers cleared. in_ready=0 while rst==0.
- Reset mid-frame discards the remaining messages of that frame. The first frame after reset starts at edge 0.
- Input handshake: a frame is accepted when in_valid && in_ready.
  - On acceptance, register min, min2, min_idx and sign_in, and compute parity = XOR of sign_in.
- in_ready = (state==IDLE) || (out_valid && out_last && out_ready). Back-to-back frames therefore run with no bubble.
- States:
  - IDLE: on accept, go to EMIT with edge counter k=0.
  - EMIT: when out_ready, k increments.
    - At k==D-1 with out_ready: go to EMIT, k=0 if a new frame is accepted the same cycle; otherwise go to IDLE.
- Latency: a frame accepted at edge t gives out_valid=1 with out_idx=0 after edge t. Frame i+1's edge 0 directly follows frame i's edge D-1 when in_valid is held.
- Output registers: out_msg, out_idx, out_last are registered and stable while out_valid && !out_ready (no change under backpressure).
- Message for edge k:
  - sel = (k==min_idx) ? min2 : min
  - mag = (sel > OFFSET) ? sel-OFFSET : 0 (unsigned, no wrap)
  - sign = parity ^ sign_in[k]
  - out_msg = {sign, mag}
- min_idx >= D: no edge matches, and every edge uses min.
- min2 equal to the odd-D pad value (2^(data_w-1)-1) passes through unchanged, then has the offset applied.
- in_valid with in_ready==0: the frame is held off, and no inputs are sampled.
- out_ready is ignored while out_valid==0.

Decomposition:
- Shared package/header: data_w, idx_w and D defaults (same values as the comparator tree); OFFSET constant; the pad-value constant.
- One natural sub-module, cnu_msg_sel: combinational per-edge select, offset saturation and sign. Instantiated once on the counter output.
- The FSM, counter and registers live in cnu_msg_expand.

Test Plan:
- Basic frame, D=7, OFFSET=1, out_ready=1:
  - Stimulus: min=3, min2=5, min_idx=2, sign_in=7'b0000101.
  - Required out_msg for edges 0..6: {1,2}, {0,2}, {1,4}, {0,2}, {0,2}, {0,2}, {0,2}.
  - out_last only on edge 6; first message one cycle after accept.
- Saturation:
  - Stimulus: min=0, min2=1, min_idx=6, sign_in=7'b1111111 (parity=1).
  - Required: all mags 0; all signs 0.
- Backpressure:
  - Stimulus: toggle out_ready 1,0,0,1,... during the basic frame.
  - Required: out_msg/out_idx held while stalled; still exactly 7 messages, in order 0..6.
- Back-to-back:
  - Stimulus: second frame (min=7, min2=9, min_idx=0, sign_in=0) with in_valid held high.
  - Required: in_ready=1 exactly in the cycle edge 6 is accepted; edge 0 of frame 2 = {0,8} in the next cycle, no gap.
- Out-of-range index:
  - Stimulus: min_idx=7 (>=D), min=4, min2=6, sign_in=0.
  - Required: all seven messages {0,3}.
- Reset mid-frame:
  - Stimulus: rst=0 after edge 3.
  - Required: next cycle out_valid=0, in_ready=0. After release, a new frame starts at out_idx=0 with correct values.

Source files
------------

// File: rtl/cnu_msg_expand_pkg.sv
// Shared widths and constants for the check-node message expander.
// The defaults here must track the ones used by the min/min2 comparator tree.
package cnu_msg_expand_pkg;

  localparam int DATA_W     = 9;
  localparam int IDX_W      = 3;
  localparam int DEG        = 7;
  localparam int CNU_OFFSET = 1;

  // The comparator tree pads odd-degree nodes with this magnitude.
  localparam int PAD_MAG = (2 ** (DATA_W - 1)) - 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/cnu_msg_sel.sv
// Per-edge message builder: picks min or min2, applies the saturating offset,
// and forms the extrinsic sign from the frame parity.
module cnu_msg_sel
  import cnu_msg_expand_pkg::*;
#(
  parameter int data_w = DATA_W,
  parameter int idx_w  = IDX_W,
  parameter int D      = DEG,
  parameter int OFFSET = CNU_OFFSET
) (
  input  logic [idx_w-1:0]  edge_i,
  input  logic [data_w-1:0] min_i,
  input  logic [data_w-1:0] min2_i,
  input  logic [idx_w-1:0]  min_idx_i,
  input  logic [D-1:0]      sign_i,
  input  logic              parity_i,
  output logic [data_w:0]   msg_o
);

  localparam logic [data_w-1:0] OFF = data_w'(OFFSET);

  logic [data_w-1:0] sel;
  logic [data_w-1:0] mag;
  logic              sgn;

  always_comb begin
    // An out-of-range min_idx never matches, so every edge falls back to min.
    sel   = (edge_i == min_idx_i) ? min2_i : min_i;
    mag   = (sel > OFF) ? (sel - OFF) : '0;
    sgn   = parity_i ^ sign_i[edge_i];
    msg_o = {sgn, mag};
  end

endmodule

// File: rtl/cnu_msg_expand.sv
// Expands one compressed check-node result into D serial sign-magnitude
// messages, one edge per accepted output beat.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no frame held; ready for a new compressed frame
//   ST_EMIT | presenting edge k of the held frame; a new frame may load
//           | in the same cycle as the last edge is taken
module cnu_msg_expand
  import cnu_msg_expand_pkg::*;
#(
  parameter int data_w = DATA_W,
  parameter int idx_w  = IDX_W,
  parameter int D      = DEG,
  parameter int OFFSET = CNU_OFFSET
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [data_w-1:0] min,
  input  logic [data_w-1:0] min2,
  input  logic [idx_w-1:0]  min_idx,
  input  logic [D-1:0]      sign_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [data_w:0]   out_msg,
  output logic [idx_w-1:0]  out_idx,
  output logic              out_last
);

  localparam logic [idx_w-1:0] LAST_K = idx_w'(D - 1);

  state_t            state_q, state_d;
  logic [data_w-1:0] min_q, min2_q;
  logic [idx_w-1:0]  min_idx_q;
  logic [D-1:0]      sign_q;
  logic              parity_q;
  logic [idx_w-1:0]  k_q, k_d;
  logic [data_w:0]   msg_q;
  logic              last_q;

  logic              accept;
  logic              take;
  logic              step;

  logic [data_w-1:0] src_min, src_min2;
  logic [idx_w-1:0]  src_idx;
  logic [D-1:0]      src_sign;
  logic              src_parity;
  logic [data_w:0]   msg_nxt;

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      min_q     <= '0;
      min2_q    <= '0;
      min_idx_q <= '0;
      sign_q    <= '0;
      parity_q  <= 1'b0;
      k_q       <= '0;
      msg_q     <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        min_q     <= min;
        min2_q    <= min2;
        min_idx_q <= min_idx;
        sign_q    <= sign_in;
        parity_q  <= src_parity;
      end
      if (accept || step) begin
        k_q    <= k_d;
        msg_q  <= msg_nxt;
        last_q <= (k_d == LAST_K);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_EMIT;
      ST_EMIT: if (take && last_q) state_d = accept ? ST_EMIT : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs and register enables.
  always_comb begin
    out_valid = (state_q == ST_EMIT);
    take      = out_valid && out_ready;
    in_ready  = rst && ((state_q == ST_IDLE) || (take && last_q));
    accept    = in_valid && in_ready;
    step      = take && !last_q;
  end

  // A freshly accepted frame is expanded straight from the inputs so edge 0
  // is registered on the accept edge; later edges come from the held copy.
  always_comb begin
    src_min    = accept ? min : min_q;
    src_min2   = accept ? min2 : min2_q;
    src_idx    = accept ? min_idx : min_idx_q;
    src_sign   = accept ? sign_in : sign_q;
    src_parity = accept ? (^sign_in) : parity_q;
    k_d        = accept ? '0 : (k_q + idx_w'(1));
  end

  cnu_msg_sel #(
    .data_w (data_w),
    .idx_w  (idx_w),
    .D      (D),
    .OFFSET (OFFSET)
  ) u_sel (
    .edge_i    (k_d),
    .min_i     (src_min),
    .min2_i    (src_min2),
    .min_idx_i (src_idx),
    .sign_i    (src_sign),
    .parity_i  (src_parity),
    .msg_o     (msg_nxt)
  );

  assign out_msg  = msg_q;
  assign out_idx  = k_q;
  assign out_last = last_q;

endmodule

// File: tb/tb_cnu_msg_expand.sv
// Scoreboard bench for cnu_msg_expand: directed frames push hand-computed
// messages, a negedge monitor pops and compares on every output handshake.
module tb_cnu_msg_expand;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [8:0] min = '0;
  logic [8:0] min2 = '0;
  logic [2:0] min_idx = '0;
  logic [6:0] sign_in = '0;
  logic       in_ready, out_valid, out_last;
  logic [9:0] out_msg;
  logic [2:0] out_idx;

  cnu_msg_expand dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .min       (min),
    .min2      (min2),
    .min_idx   (min_idx),
    .sign_in   (sign_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_msg   (out_msg),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] msg;
    logic [2:0] idx;
    logic       last;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   bp_mode = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Downstream ready: always 1, or a 1,0,0 repeating stall pattern.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    out_ready = (bp_mode != 0) ? ((cyc % 3) == 1) : 1'b1;
  end

  logic       stall_p = 1'b0;
  logic [9:0] hold_msg;
  logic [2:0] hold_idx;

  always @(negedge clk) begin
    if (rst) begin
      if (stall_p) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_msg", out_msg, hold_msg);
        chk("hold_idx", out_idx, hold_idx);
      end
      if (out_valid) chk("in_ready_eof", in_ready, out_last && out_ready);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_msg: got idx %0d msg %0h, expected none", out_idx, out_msg);
        end else begin
          e = sb.pop_front();
          chk("msg", out_msg, e.msg);
          chk("idx", out_idx, e.idx);
          chk("last", out_last, e.last);
        end
      end
      stall_p  = out_valid && !out_ready;
      hold_msg = out_msg;
      hold_idx = out_idx;
    end else begin
      stall_p = 1'b0;
    end
  end

  task automatic send(input logic [8:0] mn, input logic [8:0] mn2, input logic [2:0] ix,
                      input logic [6:0] sg, input logic [6:0][9:0] ex, input string tag);
    int   n = 0;
    logic acc = 1'b0;
    exp_t t;
    for (int k = 0; k < 7; k++) begin
      t.msg  = ex[k];
      t.idx  = 3'(k);
      t.last = (k == 6);
      sb.push_back(t);
    end
    min = mn; min2 = mn2; min_idx = ix; sign_in = sg;
    in_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL %s_accept: got no accept, expected accept within 100 cycles", tag);
    end else begin
      @(negedge clk);
      chk({tag, "_lat_valid"}, out_valid, 1);
      chk({tag, "_lat_idx"}, out_idx, 0);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drained"}, sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_idle_valid"}, out_valid, 0);
  endtask

  localparam logic [6:0][9:0] EX_BASIC = {10'h002, 10'h002, 10'h002, 10'h002, 10'h204, 10'h002, 10'h202};
  localparam logic [6:0][9:0] EX_SAT   = {7{10'h000}};
  localparam logic [6:0][9:0] EX_PAD   = {10'h009, 10'h209, 10'h209, 10'h2FE, 10'h209, 10'h209, 10'h209};
  localparam logic [6:0][9:0] EX_B2B   = {10'h006, 10'h006, 10'h006, 10'h006, 10'h006, 10'h006, 10'h008};
  localparam logic [6:0][9:0] EX_OOR   = {7{10'h003}};

  initial begin
    int n;
    // Inputs are live during reset to show nothing is sampled.
    in_valid = 1'b1; min = 9'd5; min2 = 9'd6; min_idx = 3'd1; sign_in = 7'h55;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_msg", out_msg, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_last", out_last, 0);
    chk("rst_in_ready", in_ready, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    send(9'd3, 9'd5, 3'd2, 7'b0000101, EX_BASIC, "basic");
    drain("basic");

    send(9'd0, 9'd1, 3'd6, 7'b1111111, EX_SAT, "sat");
    drain("sat");

    send(9'd10, 9'd255, 3'd3, 7'b1000000, EX_PAD, "pad");
    drain("pad");

    bp_mode = 1;
    send(9'd3, 9'd5, 3'd2, 7'b0000101, EX_BASIC, "bp");
    drain("bp");
    bp_mode = 0;

    send(9'd3, 9'd5, 3'd2, 7'b0000101, EX_BASIC, "b2b_a");
    send(9'd7, 9'd9, 3'd0, 7'b0000000, EX_B2B, "b2b_b");
    drain("b2b");

    send(9'd4, 9'd6, 3'd7, 7'b0000000, EX_OOR, "oor");
    drain("oor");

    send(9'd3, 9'd5, 3'd2, 7'b0000101, EX_BASIC, "mid");
    n = 0;
    while (!(out_valid && out_idx == 3'd3) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reach_edge3", out_idx, 3);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    send(9'd3, 9'd5, 3'd2, 7'b0000101, EX_BASIC, "post_rst");
    drain("post_rst");

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
